// File: rtl/change_dispenser.sv
// Greedy coin payout engine: splits a change amount into BIG and 1-unit coins,
// issuing one eject request per coin over a 4-phase req/ack handshake with the hopper.
module change_dispenser #(
  parameter int AMT_W = 4,
  parameter int BIG   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AMT_W-1:0] amt,
  input  logic             load,
  input  logic             ack,
  output logic             eject_big,
  output logic             eject_small,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining
);

  localparam logic [AMT_W-1:0] BIG_V = AMT_W'(BIG);
  localparam logic [AMT_W-1:0] ONE_V = AMT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             big_q, big_d;
  logic             small_q, small_d;

  // Handshake: an eject line (request) rises in SELECT->REQ and stays high until
  // ack is sampled high; the next request waits until ack has been seen low again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      big_q   <= 1'b0;
      small_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      big_q   <= big_d;
      small_q <= small_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    big_d   = big_q;
    small_d = small_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          rem_d   = amt;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (rem_q >= BIG_V) begin
          big_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          small_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Selection guaranteed rem_q >= coin value, so no underflow here.
        if (ack) begin
          big_d   = 1'b0;
          small_d = 1'b0;
          rem_d   = big_q ? (rem_q - BIG_V) : (rem_q - ONE_V);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        big_d   = 1'b0;
        small_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign eject_big   = big_q;
  assign eject_small = small_q;
  assign remaining   = rem_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a hopper model answers eject requests while a
// monitor pops hand-computed coin sequences and payout totals from scoreboard queues.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int BIG   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AMT_W-1:0] amt;
  logic             load;
  logic             ack = 1'b0;
  logic             eject_big;
  logic             eject_small;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] remaining;

  change_dispenser #(.AMT_W(AMT_W), .BIG(BIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .amt         (amt),
    .load        (load),
    .ack         (ack),
    .eject_big   (eject_big),
    .eject_small (eject_small),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AMT_W-1:0] exp_q[$];
  int               exp_total_q[$];
  int               paid = 0;
  int               done_cnt = 0;

  int ack_delay = 0;
  int ack_hold  = 1;
  int hop_phase = 0;
  int hop_cnt   = 0;

  logic             prev_big = 1'b0;
  logic             prev_small = 1'b0;
  logic             prev_busy = 1'b0;
  logic [AMT_W-1:0] prev_rem = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor first, then the hopper model, so ack seen here is what the DUT last sampled.
  always @(negedge clk) begin
    logic [AMT_W-1:0] coin;
    logic [AMT_W-1:0] exp_rem;
    if (!rst_n) begin
      prev_big   = 1'b0;
      prev_small = 1'b0;
      prev_busy  = 1'b0;
      prev_rem   = '0;
      ack        = 1'b0;
      hop_phase  = 0;
      hop_cnt    = 0;
    end else begin
      check("eject_mutex", {31'b0, eject_big & eject_small}, 0);
      if ((eject_big && !prev_big) || (eject_small && !prev_small)) begin
        coin = eject_big ? AMT_W'(BIG) : AMT_W'(1);
        check("req_while_ack_low", {31'b0, ack}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_coin: got coin %0d expected none at %0t", coin, $time);
        end else begin
          check("coin_value", coin, exp_q.pop_front());
        end
        paid += int'(coin);
      end
      if ((prev_big && !eject_big) || (prev_small && !eject_small)) begin
        coin    = prev_big ? AMT_W'(BIG) : AMT_W'(1);
        exp_rem = prev_rem - coin;
        check("drop_only_on_ack", {31'b0, ack}, 1);
        check("rem_after_coin", remaining, exp_rem);
      end
      if (prev_busy && busy) begin
        check("rem_not_increasing", {31'b0, remaining > prev_rem}, 0);
      end
      if (done) begin
        done_cnt++;
        check("done_with_busy", {31'b0, busy}, 1);
        if (exp_total_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got paid %0d expected no done at %0t", paid, $time);
        end else begin
          check("paid_total", paid, exp_total_q.pop_front());
        end
        paid = 0;
      end
      prev_big   = eject_big;
      prev_small = eject_small;
      prev_busy  = busy;
      prev_rem   = remaining;

      case (hop_phase)
        0: begin
          if (eject_big || eject_small) begin
            if (ack_delay == 0) begin
              ack       = 1'b1;
              hop_cnt   = ack_hold;
              hop_phase = 2;
            end else begin
              hop_cnt   = ack_delay;
              hop_phase = 1;
            end
          end
        end
        1: begin
          hop_cnt--;
          if (hop_cnt == 0) begin
            ack       = 1'b1;
            hop_cnt   = ack_hold;
            hop_phase = 2;
          end
        end
        default: begin
          hop_cnt--;
          if (hop_cnt == 0) begin
            ack       = 1'b0;
            hop_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic push_payout(input int n_big, input int n_small, input int total);
    for (int i = 0; i < n_big; i++) exp_q.push_back(AMT_W'(BIG));
    for (int i = 0; i < n_small; i++) exp_q.push_back(AMT_W'(1));
    exp_total_q.push_back(total);
  endtask

  task automatic do_load(input logic [AMT_W-1:0] a);
    step();
    amt  = a;
    load = 1'b1;
    step();
    load = 1'b0;
    check("busy_after_load", {31'b0, busy}, 1);
    check("rem_after_load", remaining, a);
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int start;
    logic found;
    start = done_cnt;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (done_cnt != start) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'b0, found}, 1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, {31'b0, busy}, 0);
    check({name, "_done"}, {31'b0, done}, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int dc;
    logic found;
    rst_n = 1'b0;
    load  = 1'b0;
    amt   = '0;
    repeat (3) step();
    check("rst_eject_big", {31'b0, eject_big}, 0);
    check("rst_eject_small", {31'b0, eject_small}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_remaining", remaining, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", {31'b0, busy}, 0);

    // amt=13, fast hopper: big, big, small, small, small
    ack_delay = 0;
    ack_hold  = 1;
    push_payout(2, 3, 13);
    do_load(4'd13);
    step();
    check("first_eject_big", {31'b0, eject_big}, 1);
    wait_done(200, "done_13");
    step();
    check_idle("end_13");

    // amt=0: done two cycles after the load edge, never any eject
    push_payout(0, 0, 0);
    dc = done_cnt;
    do_load(4'd0);
    check("zero_done_n", {31'b0, done}, 0);
    step();
    check("zero_done_n1", {31'b0, done}, 1);
    check("zero_busy_n1", {31'b0, busy}, 1);
    step();
    check("zero_done_n2", {31'b0, done}, 0);
    check("zero_busy_n2", {31'b0, busy}, 0);
    check("zero_done_count", done_cnt - dc, 1);

    // amt=4: four small coins only
    push_payout(0, 4, 4);
    do_load(4'd4);
    wait_done(200, "done_4");
    step();
    check_idle("end_4");

    // amt=7, slow hopper, with ignored loads of 15 while busy
    ack_delay = 10;
    ack_hold  = 5;
    push_payout(1, 2, 7);
    do_load(4'd7);
    for (int i = 0; i < 6; i++) begin
      repeat (3) step();
      amt  = 4'd15;
      load = 1'b1;
      step();
      load = 1'b0;
      amt  = 4'd0;
    end
    wait_done(400, "done_7");
    step();
    check_idle("end_7");

    // amt=10, reset pulsed while the first big request is outstanding
    ack_delay = 10;
    ack_hold  = 1;
    push_payout(2, 0, 10);
    do_load(4'd10);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (eject_big) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_case_req_seen", {31'b0, found}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_eject_big", {31'b0, eject_big}, 0);
    check("abort_eject_small", {31'b0, eject_small}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_remaining", remaining, 0);
    exp_q.delete();
    exp_total_q.delete();
    paid = 0;
    dc = done_cnt;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_idle_busy", {31'b0, busy}, 0);

    ack_delay = 0;
    ack_hold  = 1;
    push_payout(1, 1, 6);
    do_load(4'd6);
    wait_done(200, "done_6");
    step();
    check_idle("end_6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out a change amount as physical coins through a 4-phase handshake with the coin hopper. It sits on the far side of the vending machine's change-return path: it accepts the gated 4-bit change value and a load strobe from the controller. It then issues one eject request per coin, greedy largest-first, until the amount is exhausted.

## Interface
- AMT_W, 4, width of change amount and remaining counter
- BIG, 5, value of the large coin; small coin is fixed at 1; legal range 2..2^AMT_W-1
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- amt  input  AMT_W  change amount to dispense; sampled only on an accepted load
- load  input  1  start strobe; accepted only when busy=0
- ack  input  1  hopper acknowledge, 4-phase; high = coin ejected
- eject_big  output  1  request one BIG coin; registered
- eject_small  output  1  request one 1-unit coin; registered
- busy  output  1  high from the cycle after an accepted load until dispensing completes
- done  output  1  one-cycle pulse at completion
- remaining  output  AMT_W  amount still to dispense; registered

## Operation
- States: IDLE, SELECT, REQ, RELEASE, DONE.
- IDLE: busy=0. If load=1, then rem<=amt and go to SELECT.
- SELECT:
  - rem==0 -> DONE.
  - rem>=BIG -> eject_big<=1, go to REQ.
  - otherwise -> eject_small<=1, go to REQ.
- REQ: hold the asserted eject line until ack=1. On ack=1:
  - clear the eject line;
  - rem<=rem-BIG (big) or rem-1 (small); never underflows, because selection guarantees rem>=coin;
  - go to RELEASE.
- RELEASE: wait for ack=0, then go to SELECT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- At most one eject line is high at any time. Never both.
- busy=1 in SELECT, REQ, RELEASE and DONE; busy=0 only in IDLE.
- load while busy is ignored; amt is not resampled.
- ack is ignored in IDLE, SELECT and DONE.
- ack already high on entry to REQ counts as acknowledge. It cannot be stale, because RELEASE has already seen ack=0.
- Reset values: state=IDLE, eject_big=0, eject_small=0, busy=0, done=0, remaining=0.
- Reset asserted mid-operation aborts immediately:
  - eject lines drop asynchronously;
  - the partial payout is lost;
  - no done pulse is issued.

## Timing
- Load sampled at edge n: after n, busy=1 and remaining=amt.
- After edge n+1: the first eject line is high.
- ack=1 sampled at edge m: after m, the eject line is low and remaining has decremented.
- ack=0 sampled at edge k: after k, state is SELECT. After k+1, the next eject line is high, or done=1.
- Minimum per-coin cost with single-cycle ack high and low: 3 cycles (SELECT, REQ, RELEASE).
- amt=0: load at edge n -> done=1 after n+1 -> done=0 and busy=0 after n+2. No eject is ever asserted.
- Completion: done and busy=1 coincide for one cycle. busy falls together with done.
- A new load is accepted at the first edge where busy=0, i.e. the cycle after the done pulse.

## Test plan
- amt=13, BIG=5, ack responds 1 cycle after each request and releases 1 cycle later:
  - ejects big, big, small, small, small;
  - remaining 13->8->3->2->1->0;
  - one done pulse; busy low after it.
- amt=0 -> no eject; done high exactly 2 cycles after the load edge; busy high for exactly 2 cycles.
- amt=4 -> four eject_small requests and no eject_big; remaining counts 4->3->2->1->0.
- amt=7, slow hopper (ack delayed 10 cycles, held high 5 cycles):
  - the eject line stays high until ack is sampled;
  - no new request until ack=0;
  - load pulses with amt=15 during busy are ignored and the total paid stays 7.
- Reset pulsed low during REQ of amt=10:
  - eject_big drops immediately;
  - all outputs are at reset values;
  - no done pulse;
  - a subsequent load of amt=6 dispenses big, small normally.
- Throughout all scenarios, check:
  - eject_big and eject_small are never high together;
  - remaining never increases while busy;
  - the sum of coin values dispensed equals amt.
